mem_arbiter: RTL and testbench

Shares one unified memory (the tagged `mem` model, 2-bit command / 4-bit tag protocol) between the processor's instruction-fetch port and its data-memory port. This replaces the separate IM/DM instances.
Each cycle it selects one requester and forwards its command to memory, returning the accepted/rejected status to the requester that issued it. An owner table indexed by tag routes each returned load to the correct port.
The data port has fixed priority, with an anti-starvation counter that guarantees fetch progress.

---
 rtl/sys_defs.sv | 21 ++
 rtl/arb_tag_table.sv | 36 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared bus protocol definitions for the unified tagged memory interface.
package sys_defs;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int TAG_W    = 4;
  localparam int STARVE_W = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_entry_t;

endpackage

// File: rtl/arb_tag_table.sv
// Owner table: one {valid, owner} entry per memory tag, written on issue and
// cleared on return; an issue to the same tag in the same cycle wins.
module arb_tag_table #(
  parameter int TAG_W = sys_defs::TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [TAG_W-1:0]     i_wr_tag,
  input  sys_defs::owner_e     i_wr_owner,
  input  logic                 i_clr_en,
  input  logic [TAG_W-1:0]     i_rd_tag,
  output sys_defs::tag_entry_t o_rd_entry
);
  import sys_defs::*;

  localparam int DEPTH = 1 << TAG_W;

  tag_entry_t r_table [DEPTH];

  // NOTE: the table is flops, not RAM; every valid bit must reset so that
  // stale pre-reset tags are recognised as unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else begin
      if (i_clr_en) r_table[i_rd_tag].valid <= 1'b0;
      // NOTE: the later non-blocking write wins, giving issue precedence
      // over a same-tag clear.
      if (i_wr_en)  r_table[i_wr_tag] <= '{valid: 1'b1, owner: i_wr_owner};
    end
  end

  assign o_rd_entry = r_table[i_rd_tag];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one tagged memory, with data
// priority, a fetch anti-starvation counter and tag-routed load returns.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W        = sys_defs::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       if_cmd,
  input  logic [31:0]      if_addr,
  output logic             if_grant,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic [1:0]       dm_cmd,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic             dm_grant,
  output logic             dm_rvalid,
  output logic [31:0]      dm_rdata,
  output logic [1:0]       proc2mem_command,
  output logic [31:0]      proc2mem_addr,
  output logic [31:0]      proc2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [31:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic             tag_err
);
  import sys_defs::*;

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_tag_err;

  logic       w_if_req, w_dm_req, w_force_if;
  logic       w_sel_if, w_sel_dm, w_accept;
  logic       w_issue_load, w_ret;
  owner_e     w_issue_owner;
  tag_entry_t w_ret_entry;

  // Outputs are combinational, so requests are masked while reset is held.
  assign w_if_req   = !rst && (if_cmd != BUS_NONE);
  assign w_dm_req   = !rst && (dm_cmd != BUS_NONE);
  assign w_force_if = w_if_req && (r_starve_cnt == LIMIT);
  assign w_sel_dm   = w_dm_req && !w_force_if;
  assign w_sel_if   = w_if_req && !w_sel_dm;
  assign w_accept   = (mem2proc_response != '0);

  assign if_grant = w_sel_if && w_accept;
  assign dm_grant = w_sel_dm && w_accept;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (w_sel_dm) begin
      proc2mem_command = dm_cmd;
      proc2mem_addr    = dm_addr;
      proc2mem_data    = dm_wdata;
    end else if (w_sel_if) begin
      proc2mem_command = if_cmd;
      proc2mem_addr    = if_addr;
    end
  end

  assign w_issue_load  = (if_grant || dm_grant) && (proc2mem_command == BUS_LOAD);
  assign w_issue_owner = w_sel_dm ? OWN_DM : OWN_IF;
  assign w_ret         = !rst && (mem2proc_tag != '0);

  arb_tag_table #(.TAG_W(TAG_W)) u_tag_table (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_issue_load),
    .i_wr_tag   (mem2proc_response),
    .i_wr_owner (w_issue_owner),
    .i_clr_en   (w_ret),
    .i_rd_tag   (mem2proc_tag),
    .o_rd_entry (w_ret_entry)
  );

  assign if_rvalid = w_ret && w_ret_entry.valid && (w_ret_entry.owner == OWN_IF);
  assign dm_rvalid = w_ret && w_ret_entry.valid && (w_ret_entry.owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem2proc_data : '0;
  assign dm_rdata  = dm_rvalid ? mem2proc_data : '0;
  assign tag_err   = r_tag_err;

  // Forced priority holds while memory keeps rejecting, since only a grant
  // or an idle fetch port clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_tag_err    <= 1'b0;
    end else begin
      if (w_if_req && !if_grant) begin
        if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
      if (w_ret && !w_ret_entry.valid) r_tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour
// plus hand sequences for starvation, unknown tags and reset mid-operation.
module tb_mem_arbiter;
  import sys_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  if_cmd, dm_cmd;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_grant, if_rvalid, dm_grant, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [31:0] mem2proc_data;
  logic        tag_err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_cmd(if_cmd), .if_addr(if_addr), .if_grant(if_grant),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_grant(dm_grant), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  if_cmd;
    logic [31:0] if_addr;
    logic [1:0]  dm_cmd;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  resp;
    logic [31:0] mdata;
    logic [3:0]  mtag;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_ig, e_dg, e_iv;
    logic [31:0] e_ird;
    logic        e_dv;
    logic [31:0] e_drd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive on the falling edge; outputs are then sampled 1 ns later.
  task automatic drive(input logic r, input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [31:0] dw,
                       input logic [3:0] resp, input logic [31:0] md, input logic [3:0] mt);
    @(negedge clk);
    rst = r; if_cmd = ic; if_addr = ia; dm_cmd = dc; dm_addr = da; dm_wdata = dw;
    mem2proc_response = resp; mem2proc_data = md; mem2proc_tag = mt;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
  endtask

  function automatic vec_t mk(logic r, logic [1:0] ic, logic [31:0] ia, logic [1:0] dc,
                              logic [31:0] da, logic [31:0] dw, logic [3:0] resp,
                              logic [31:0] md, logic [3:0] mt, logic [1:0] ec,
                              logic [31:0] ea, logic [31:0] ed, logic ig, logic dg,
                              logic iv, logic [31:0] ird, logic dv, logic [31:0] drd,
                              logic err);
    vec_t v;
    v = '{r, ic, ia, dc, da, dw, resp, md, mt, ec, ea, ed, ig, dg, iv, ird, dv, drd, err};
    return v;
  endfunction

  // Fetch and data both request every cycle; forced priority arrives on the
  // fifth cycle and, if rejected there, must persist into the next cycle.
  task automatic starve_run(input bit reject, input string tag);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, BUS_LOAD, 32'h500, BUS_LOAD, 32'h600, 0, 4'd1, 0, 0);
      check($sformatf("%s_deny%0d_dg", tag, k), dm_grant, 1);
      check($sformatf("%s_deny%0d_ig", tag, k), if_grant, 0);
    end
    if (reject) begin
      drive(1'b0, BUS_LOAD, 32'h500, BUS_LOAD, 32'h600, 0, 4'd0, 0, 0);
      check({tag, "_rej_addr"}, proc2mem_addr, 32'h500);
      check({tag, "_rej_ig"}, if_grant, 0);
      check({tag, "_rej_dg"}, dm_grant, 0);
    end
    drive(1'b0, BUS_LOAD, 32'h500, BUS_LOAD, 32'h600, 0, 4'd2, 0, 0);
    check({tag, "_force_ig"}, if_grant, 1);
    check({tag, "_force_dg"}, dm_grant, 0);
    check({tag, "_force_addr"}, proc2mem_addr, 32'h500);
    drive(1'b0, BUS_LOAD, 32'h504, BUS_LOAD, 32'h600, 0, 4'd3, 0, 0);
    check({tag, "_after_dg"}, dm_grant, 1);
    check({tag, "_after_ig"}, if_grant, 0);
  endtask

  initial begin
    rst = 1'b1; if_cmd = 0; if_addr = 0; dm_cmd = 0; dm_addr = 0; dm_wdata = 0;
    mem2proc_response = 0; mem2proc_data = 0; mem2proc_tag = 0;

    //              rst ic        ia      dc         da      dw            rsp md            mt  ecmd       eaddr   edata        ig dg iv ird           dv drd          err
    vecs.push_back(mk(1, 0,        0,      0,         0,      0,            0,  0,            0,  BUS_NONE,  0,      0,            0, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  0,            0,  BUS_NONE,  0,      0,            0, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, BUS_LOAD, 'h40,   0,         0,      0,            3,  0,            0,  BUS_LOAD,  'h40,   0,            1, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  0,            0,  BUS_NONE,  0,      0,            0, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  0,            0,  BUS_NONE,  0,      0,            0, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  'h11112222,   3,  BUS_NONE,  0,      0,            0, 0, 1, 'h11112222,   0, 0,            0));
    vecs.push_back(mk(0, BUS_LOAD, 'h80,   BUS_STORE, 'h100,  'hDEADBEEF,   7,  0,            0,  BUS_STORE, 'h100,  'hDEADBEEF,   0, 1, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, BUS_LOAD, 'h80,   0,         0,      0,            1,  0,            0,  BUS_LOAD,  'h80,   0,            1, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      BUS_LOAD,  'h200,  'h55,         2,  0,            0,  BUS_LOAD,  'h200,  'h55,         0, 1, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  'hAAAA0002,   2,  BUS_NONE,  0,      0,            0, 0, 0, 0,            1, 'hAAAA0002,   0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  'hBBBB0001,   1,  BUS_NONE,  0,      0,            0, 0, 1, 'hBBBB0001,   0, 0,            0));
    vecs.push_back(mk(0, BUS_LOAD, 'h90,   0,         0,      0,            4,  0,            0,  BUS_LOAD,  'h90,   0,            1, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      BUS_LOAD,  'h300,  0,            4,  'hCCCC0004,   4,  BUS_LOAD,  'h300,  0,            0, 1, 1, 'hCCCC0004,   0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  'hDDDD0004,   4,  BUS_NONE,  0,      0,            0, 0, 0, 0,            1, 'hDDDD0004,   0));
    vecs.push_back(mk(0, 0,        0,      BUS_LOAD,  'h400,  0,            0,  0,            0,  BUS_LOAD,  'h400,  0,            0, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  'h99,         3,  BUS_NONE,  0,      0,            0, 0, 0, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,        0,      0,         0,      0,            0,  0,            0,  BUS_NONE,  0,      0,            0, 0, 0, 0,            0, 0,            1));
    vecs.push_back(mk(1, BUS_LOAD, 'h44,   BUS_LOAD,  'h48,   'h1,          5,  'h77,         5,  BUS_NONE,  0,      0,            0, 0, 0, 0,            0, 0,            0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.if_cmd, v.if_addr, v.dm_cmd, v.dm_addr, v.dm_wdata, v.resp, v.mdata, v.mtag);
      check($sformatf("v%0d_cmd", i),   proc2mem_command, v.e_cmd);
      check($sformatf("v%0d_addr", i),  proc2mem_addr, v.e_addr);
      check($sformatf("v%0d_data", i),  proc2mem_data, v.e_data);
      check($sformatf("v%0d_ig", i),    if_grant, v.e_ig);
      check($sformatf("v%0d_dg", i),    dm_grant, v.e_dg);
      check($sformatf("v%0d_iv", i),    if_rvalid, v.e_iv);
      check($sformatf("v%0d_ird", i),   if_rdata, v.e_ird);
      check($sformatf("v%0d_dv", i),    dm_rvalid, v.e_dv);
      check($sformatf("v%0d_drd", i),   dm_rdata, v.e_drd);
      check($sformatf("v%0d_err", i),   tag_err, v.e_err);
    end

    starve_run(1'b0, "starve");
    starve_run(1'b1, "starve_rej");

    // Unknown tag: no routing, sticky error until reset.
    do_reset();
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 32'h1234, 4'd5);
    check("unk_iv", if_rvalid, 0);
    check("unk_dv", dm_rvalid, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
      check($sformatf("unk_err_hold%0d", k), tag_err, 1);
    end
    drive(1'b1, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
    check("unk_err_rst", tag_err, 0);

    // Reset with two loads outstanding.
    drive(1'b0, BUS_LOAD, 32'h60, BUS_NONE, 0, 0, 4'd6, 0, 0);
    check("rmid_ig", if_grant, 1);
    drive(1'b0, BUS_NONE, 0, BUS_LOAD, 32'h64, 0, 4'd7, 0, 0);
    check("rmid_dg", dm_grant, 1);
    drive(1'b1, BUS_LOAD, 32'h68, BUS_LOAD, 32'h6C, 32'h5, 4'd8, 32'h42, 4'd6);
    check("rmid_rst_cmd", proc2mem_command, BUS_NONE);
    check("rmid_rst_addr", proc2mem_addr, 0);
    check("rmid_rst_ig", if_grant, 0);
    check("rmid_rst_dg", dm_grant, 0);
    check("rmid_rst_iv", if_rvalid, 0);
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 32'h42, 4'd6);
    check("rmid_post_iv", if_rvalid, 0);
    check("rmid_post_dv", dm_rvalid, 0);
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 32'h43, 4'd7);
    check("rmid_post7_dv", dm_rvalid, 0);
    check("rmid_err", tag_err, 1);
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
    check("rmid_err_hold", tag_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
